// File: rtl/alu_serial_engine_if.sv
// Execute-phase handshake and operand/result bus between the control FSM and the serial ALU.
interface alu_serial_engine_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en_group_pulse;
    logic [2:0]       alu_func;
    logic             alu_in_sel;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] opb_imm;
    logic [WIDTH-1:0] alu_result;
    logic             alu_end;
    logic             busy;
    logic             flag_c;
    logic             flag_z;

    modport master (
        output en_group_pulse, alu_func, alu_in_sel, opa, opb_reg, opb_imm,
        input  alu_result, alu_end, busy, flag_c, flag_z
    );

    modport slave (
        input  en_group_pulse, alu_func, alu_in_sel, opa, opb_reg, opb_imm,
        output alu_result, alu_end, busy, flag_c, flag_z
    );
endinterface

// File: rtl/alu_serial_engine.sv
// Digit-serial ALU: DIGIT bits per cycle, LSB digit first, one-cycle alu_end on completion.
// Define ALU_SERIAL_FLAGS_EN to build the carry/zero flag registers; otherwise flags read 0.
module alu_serial_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic                clk,
    input logic                rst,
    alu_serial_engine_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] FuncMoveb = 3'b000;
    localparam logic [2:0] FuncAdd   = 3'b001;
    localparam logic [2:0] FuncSub   = 3'b010;
    localparam logic [2:0] FuncAnd   = 3'b011;
    localparam logic [2:0] FuncOr    = 3'b100;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       func_q, func_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             end_q;
    logic             busy_q, busy_d;

    logic [DIGIT-1:0]       a_dig, b_dig, b_op, res_dig;
    logic [DIGIT:0]         sum;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_shifted;
    logic                   carry_out;
    logic                   last_digit;

    // Per-digit datapath; SUB is A + ~B + c with c seeded to 1 at start.
    always_comb begin
        a_dig     = a_q[DIGIT-1:0];
        b_dig     = b_q[DIGIT-1:0];
        b_op      = (func_q == FuncSub) ? ~b_dig : b_dig;
        sum       = {1'b0, a_dig} + {1'b0, b_op} + {{DIGIT{1'b0}}, carry_q};
        carry_out = sum[DIGIT];
        case (func_q)
            FuncMoveb: res_dig = b_dig;
            FuncAdd,
            FuncSub:   res_dig = sum[DIGIT-1:0];
            FuncAnd:   res_dig = a_dig & b_dig;
            FuncOr:    res_dig = a_dig | b_dig;
            default:   res_dig = '0;
        endcase
        res_cat     = {res_dig, res_q};
        res_shifted = res_cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        func_d     = func_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        busy_d     = busy_q;
        last_digit = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.en_group_pulse) begin
                    a_d     = bus.opa;
                    b_d     = bus.alu_in_sel ? bus.opb_imm : bus.opb_reg;
                    func_d  = bus.alu_func;
                    carry_d = (bus.alu_func == FuncSub);
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StBusy;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StBusy: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_shifted;
                carry_d = carry_out;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    last_digit = 1'b1;
                    result_d   = res_shifted;
                    busy_d     = 1'b0;
                    state_d    = StDone;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            func_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            func_q   <= func_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            end_q    <= last_digit;
            busy_q   <= busy_d;
        end
    end

    assign bus.alu_result = result_q;
    assign bus.alu_end    = end_q;
    assign bus.busy       = busy_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic flag_c_q, flag_z_q;
    logic arith_op;

    assign arith_op = (func_q == FuncAdd) || (func_q == FuncSub);

    // Carry only tracks ADD/SUB; logic ops leave the previous carry in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (last_digit) begin
            flag_z_q <= (res_shifted == '0);
            if (arith_op) begin
                flag_c_q <= carry_out;
            end
        end
    end

    assign bus.flag_c = flag_c_q;
    assign bus.flag_z = flag_z_q;
`else
    assign bus.flag_c = 1'b0;
    assign bus.flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_engine.sv
// Scoreboard bench for alu_serial_engine: stimulus pushes expected results, a negedge monitor
// pops and compares on every alu_end.
module tb_alu_serial_engine;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIGIT = 2;
    localparam int unsigned N     = WIDTH / DIGIT;
`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_serial_engine_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_engine #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every completion against the scoreboard head.
    initial begin : monitor
        exp_t             e;
        int               busy_cnt;
        bit               hold_chk;
        logic [WIDTH-1:0] hold_val;
        busy_cnt = 0;
        hold_chk = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt = 0;
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    chk("result_hold", 32'(bus.alu_result), 32'(hold_val));
                    hold_chk = 1'b0;
                end
                if (bus.busy) busy_cnt++;
                if (bus.alu_end) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_end: alu_end with no pending op (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(bus.alu_result), 32'(e.res));
                        chk("flag_c", 32'(bus.flag_c), 32'(e.c));
                        chk("flag_z", 32'(bus.flag_z), 32'(e.z));
                        chk("end_cycle", 32'(cyc), 32'(e.cyc));
                        chk("busy_cycles", 32'(busy_cnt), 32'(N));
                        chk("busy_at_end", 32'(bus.busy), 32'd0);
                        hold_val = e.res;
                        hold_chk = 1'b1;
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Caller is positioned at a negedge; returns at the following negedge.
    task automatic start_op(input logic [2:0] f, input logic sel, input logic [7:0] a,
                            input logic [7:0] br, input logic [7:0] bi, input logic [7:0] res,
                            input logic c, input logic z, input bit expect_end);
        exp_t e;
        bus.en_group_pulse = 1'b1;
        bus.alu_func       = f;
        bus.alu_in_sel     = sel;
        bus.opa            = a;
        bus.opb_reg        = br;
        bus.opb_imm        = bi;
        if (expect_end) begin
            e.res = res;
            e.c   = FlagsEn ? c : 1'b0;
            e.z   = FlagsEn ? z : 1'b0;
            e.cyc = cyc + N + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.en_group_pulse = 1'b0;
        bus.alu_func       = f ^ 3'b011;
        bus.alu_in_sel     = ~sel;
        bus.opa            = ~a;
        bus.opb_reg        = ~br;
        bus.opb_imm        = ~bi;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!bus.alu_end && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.alu_end) begin
            checks++;
            errors++;
            $display("FAIL %s: no alu_end within 20 cycles, got 0 expected 1", name);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic sel,
                          input logic [7:0] a, input logic [7:0] br, input logic [7:0] bi,
                          input logic [7:0] res, input logic c, input logic z);
        start_op(f, sel, a, br, bi, res, c, z, 1'b1);
        wait_end(name);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.en_group_pulse = 1'b0;
        bus.alu_func       = 3'b000;
        bus.alu_in_sel     = 1'b0;
        bus.opa            = '0;
        bus.opb_reg        = '0;
        bus.opb_imm        = '0;
        #12;
        chk("rst_result", 32'(bus.alu_result), 32'd0);
        chk("rst_end", 32'(bus.alu_end), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flag_c", 32'(bus.flag_c), 32'd0);
        chk("rst_flag_z", 32'(bus.flag_z), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("add",      3'b001, 1'b0, 8'h5A, 8'h3C, 8'h77, 8'h96, 1'b0, 1'b0);
        run_op("sub_eq",   3'b010, 1'b1, 8'h10, 8'h77, 8'h10, 8'h00, 1'b1, 1'b1);
        run_op("sub_brw",  3'b010, 1'b0, 8'h01, 8'h02, 8'h77, 8'hFF, 1'b0, 1'b0);
        run_op("and",      3'b011, 1'b0, 8'hF0, 8'h3C, 8'h77, 8'h30, 1'b0, 1'b0);
        run_op("or",       3'b100, 1'b0, 8'hF0, 8'h0F, 8'h77, 8'hFF, 1'b0, 1'b0);
        run_op("moveb",    3'b000, 1'b0, 8'h33, 8'hA5, 8'h77, 8'hA5, 1'b0, 1'b0);
        run_op("add_wrap", 3'b001, 1'b0, 8'hFF, 8'h01, 8'h77, 8'h00, 1'b1, 1'b1);
        run_op("and_keepc",3'b011, 1'b0, 8'h0F, 8'hF0, 8'h77, 8'h00, 1'b1, 1'b1);
        run_op("moveb_imm",3'b000, 1'b1, 8'h33, 8'h77, 8'hA5, 8'hA5, 1'b1, 1'b0);

        // Second pulse while busy must be dropped.
        start_op(3'b001, 1'b0, 8'h12, 8'h34, 8'h77, 8'h46, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.en_group_pulse = 1'b1;
        bus.alu_func       = 3'b010;
        bus.opa            = 8'h99;
        bus.opb_reg        = 8'h11;
        @(negedge clk);
        bus.en_group_pulse = 1'b0;
        wait_end("ignored_pulse");
        @(negedge clk);

        // Back-to-back: next start issued in the DONE cycle.
        start_op(3'b001, 1'b0, 8'h80, 8'h80, 8'h77, 8'h00, 1'b1, 1'b1, 1'b1);
        wait_end("b2b_first");
        start_op(3'b010, 1'b1, 8'h05, 8'h77, 8'h03, 8'h02, 1'b1, 1'b0, 1'b1);
        wait_end("b2b_second");
        @(negedge clk);

        // Reset in cycle 3 aborts with no completion.
        start_op(3'b001, 1'b0, 8'h11, 8'h22, 8'h77, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_result", 32'(bus.alu_result), 32'd0);
        chk("abort_end", 32'(bus.alu_end), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_flag_c", 32'(bus.flag_c), 32'd0);
        chk("abort_flag_z", 32'(bus.flag_z), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        run_op("add_post", 3'b001, 1'b0, 8'hF0, 8'h20, 8'h77, 8'h10, 1'b1, 1'b0);
        run_op("rsv_101",  3'b101, 1'b0, 8'h5A, 8'h3C, 8'h77, 8'h00, 1'b1, 1'b1);
        run_op("rsv_110",  3'b110, 1'b0, 8'hFF, 8'hFF, 8'h77, 8'h00, 1'b1, 1'b1);

        repeat (6) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
